// File: rtl/led_pattern_seq_if.sv
// -----------------------------------------------------------------------------
// led_pattern_seq_if
// Bundles the pattern sequencer's functional signals. Clock and reset stay
// plain ports on the sequencer.
//   CE   : step enable, one C cycle wide, synchronous to C
//   BTN  : raw push-button, active-high, asynchronous, bouncing
//   LEDS : LED drive, bit0 = LD0 (registered in the sequencer)
//   MODE : current pattern mode (registered in the sequencer)
// The slave modport is the sequencer's view; master is the driver's view.
// -----------------------------------------------------------------------------
interface led_pattern_seq_if;
   logic       CE;
   logic       BTN;
   logic [3:0] LEDS;
   logic [1:0] MODE;

   modport slave (
      input  CE,
      input  BTN,
      output LEDS,
      output MODE
   );

   modport master (
      output CE,
      output BTN,
      input  LEDS,
      input  MODE
   );
endinterface

// File: rtl/led_pattern_seq.sv
// -----------------------------------------------------------------------------
// led_pattern_seq
// Drives the four on-board LEDs from a 10 Hz step enable using one of four
// button-selectable patterns: binary count, scanner, blink-all and dimmed-on.
// The raw button is synchronised, debounced, and each accepted press steps
// the mode. Everything runs on the 1 MHz clock C; CE is only an enable.
//
// Ports:
//   C    in   1 MHz clock, rising edge
//   CLR  in   asynchronous active-high reset
//   bus  slave modport of led_pattern_seq_if (CE, BTN in; LEDS, MODE out)
//
// Parameters:
//   DEB_CYCLES  stable cycles needed to accept a button level change (2..65535)
//   DIM_DUTY    on-slots out of 16 in DIM mode (0..16)
// -----------------------------------------------------------------------------
module led_pattern_seq #(
   parameter int DEB_CYCLES = 20000,
   parameter int DIM_DUTY   = 4
) (
   input  logic                 C,
   input  logic                 CLR,
   led_pattern_seq_if.slave     bus
);

   // Terminal debounce count and the 5-bit duty threshold, so that a duty of
   // 16 compares above every 4-bit PWM value.
   localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);
   localparam logic [4:0]  DUTY     = 5'(DIM_DUTY);

   typedef enum logic [1:0] {
      MODE_BINARY = 2'b00,
      MODE_SCAN   = 2'b01,
      MODE_BLINK  = 2'b10,
      MODE_DIM    = 2'b11
   } mode_e;

   // Scanner position to one-hot LED pattern.
   function automatic logic [3:0] scan_onehot(input logic [1:0] pos);
      logic [3:0] pat;
      case (pos)
         2'd0:    pat = 4'b0001;
         2'd1:    pat = 4'b0010;
         2'd2:    pat = 4'b0100;
         2'd3:    pat = 4'b1000;
         default: pat = 4'b0000;
      endcase
      return pat;
   endfunction

   // DIM-mode LED pattern for a given PWM slot.
   function automatic logic [3:0] dim_pattern(input logic [3:0] pwm);
      logic [3:0] pat;
      if ({1'b0, pwm} < DUTY) begin
         pat = 4'b1111;
      end else begin
         pat = 4'b0000;
      end
      return pat;
   endfunction

   logic        sync1_q,      sync1_d;
   logic        sync2_q,      sync2_d;
   logic        deb_level_q,  deb_level_d;
   logic [15:0] deb_cnt_q,    deb_cnt_d;
   mode_e       mode_q,       mode_d;
   logic [3:0]  count_q,      count_d;
   logic [1:0]  scan_pos_q,   scan_pos_d;
   logic        scan_down_q,  scan_down_d;
   logic        blink_q,      blink_d;
   logic [3:0]  pwm_q,        pwm_d;
   logic [3:0]  leds_q,       leds_d;

   logic        btn_s;
   logic        press_s;

   // State register: every flop returns to its idle value on CLR.
   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         deb_level_q <= 1'b0;
         deb_cnt_q   <= 16'd0;
         mode_q      <= MODE_BINARY;
         count_q     <= 4'd0;
         scan_pos_q  <= 2'd0;
         scan_down_q <= 1'b0;
         blink_q     <= 1'b0;
         pwm_q       <= 4'd0;
         leds_q      <= 4'b0000;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         deb_level_q <= deb_level_d;
         deb_cnt_q   <= deb_cnt_d;
         mode_q      <= mode_d;
         count_q     <= count_d;
         scan_pos_q  <= scan_pos_d;
         scan_down_q <= scan_down_d;
         blink_q     <= blink_d;
         pwm_q       <= pwm_d;
         leds_q      <= leds_d;
      end
   end

   // Next-state logic: synchroniser, debouncer, mode FSM, patterns, LED drive.
   always_comb begin
      sync1_d     = bus.BTN;
      sync2_d     = sync1_q;
      btn_s       = sync2_q;
      deb_level_d = deb_level_q;
      deb_cnt_d   = deb_cnt_q;
      mode_d      = mode_q;
      count_d     = count_q;
      scan_pos_d  = scan_pos_q;
      scan_down_d = scan_down_q;
      blink_d     = blink_q;
      leds_d      = leds_q;
      press_s     = 1'b0;

      // The PWM slot counter is free-running in every mode.
      pwm_d = pwm_q + 4'd1;

      // The counter only runs while the synchronised input disagrees with the
      // accepted level; any return to agreement restarts the qualification.
      // The press pulse is generated combinationally on the accepting cycle so
      // the mode advances on the same edge the debounced level rises.
      if (btn_s != deb_level_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            deb_level_d = btn_s;
            deb_cnt_d   = 16'd0;
            press_s     = btn_s;
         end else begin
            deb_cnt_d   = deb_cnt_q + 16'd1;
         end
      end else begin
         deb_cnt_d = 16'd0;
      end

      // A press takes priority over a coincident CE, which is dropped.
      if (press_s) begin
         case (mode_q)
            MODE_BINARY: mode_d = MODE_SCAN;
            MODE_SCAN:   mode_d = MODE_BLINK;
            MODE_BLINK:  mode_d = MODE_DIM;
            MODE_DIM:    mode_d = MODE_BINARY;
            default:     mode_d = MODE_BINARY;
         endcase
         count_d     = 4'd0;
         scan_pos_d  = 2'd0;
         scan_down_d = 1'b0;
         blink_d     = 1'b0;
      end else if (bus.CE) begin
         case (mode_q)
            MODE_BINARY: begin
               count_d = count_q + 4'd1;
            end
            MODE_SCAN: begin
               // Direction flips as an end LED is reached, so ends light once.
               if (scan_down_q) begin
                  scan_pos_d = scan_pos_q - 2'd1;
                  if (scan_pos_q == 2'd1) begin
                     scan_down_d = 1'b0;
                  end else begin
                     scan_down_d = scan_down_q;
                  end
               end else begin
                  scan_pos_d = scan_pos_q + 2'd1;
                  if (scan_pos_q == 2'd2) begin
                     scan_down_d = 1'b1;
                  end else begin
                     scan_down_d = scan_down_q;
                  end
               end
            end
            MODE_BLINK: begin
               blink_d = ~blink_q;
            end
            MODE_DIM: begin
               count_d = count_q;
            end
            default: begin
               count_d = count_q;
            end
         endcase
      end else begin
         mode_d = mode_q;
      end

      // LEDS is derived from next state so a step or mode change shows on
      // the same edge that causes it.
      case (mode_d)
         MODE_BINARY: leds_d = count_d;
         MODE_SCAN:   leds_d = scan_onehot(scan_pos_d);
         MODE_BLINK:  leds_d = {4{blink_d}};
         MODE_DIM:    leds_d = dim_pattern(pwm_d);
         default:     leds_d = 4'b0000;
      endcase
   end

   assign bus.LEDS = leds_q;
   assign bus.MODE = mode_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_seq
// Directed bench for led_pattern_seq with DEB_CYCLES=4. Three instances share
// stimulus and differ only in DIM_DUTY (4, 0, 16). Inputs change 1 ns after
// a rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_led_pattern_seq;

   logic C = 1'b0;
   logic CLR;
   logic ce;
   logic btn;

   int n_err   = 0;
   int n_chk   = 0;
   int n_edges = 0;   // clock edges since CLR released: the expected PWM slot

   always #5 C = ~C;

   led_pattern_seq_if bus_a ();
   led_pattern_seq_if bus_z ();
   led_pattern_seq_if bus_f ();

   assign bus_a.CE  = ce;
   assign bus_a.BTN = btn;
   assign bus_z.CE  = ce;
   assign bus_z.BTN = btn;
   assign bus_f.CE  = ce;
   assign bus_f.BTN = btn;

   led_pattern_seq #(.DEB_CYCLES(4), .DIM_DUTY(4)) dut_a (
      .C   (C),
      .CLR (CLR),
      .bus (bus_a.slave)
   );

   led_pattern_seq #(.DEB_CYCLES(4), .DIM_DUTY(0)) dut_z (
      .C   (C),
      .CLR (CLR),
      .bus (bus_z.slave)
   );

   led_pattern_seq #(.DEB_CYCLES(4), .DIM_DUTY(16)) dut_f (
      .C   (C),
      .CLR (CLR),
      .bus (bus_f.slave)
   );

   task automatic tick();
      @(posedge C);
      if (!CLR) begin
         n_edges++;
      end
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] dim_exp(input int duty);
      return ((n_edges % 16) < duty) ? 4'hF : 4'h0;
   endfunction

   // Four-cycle-stable press followed by release; mode must step on the
   // sixth edge (2 sync + 4 debounce) and must not move on release.
   task automatic press(input logic [1:0] exp_mode, input logic [3:0] exp_leds);
      logic [1:0] prev_mode;
      prev_mode = exp_mode - 2'd1;
      btn = 1'b1;
      repeat (5) tick();
      chk("press_early", {6'd0, bus_a.MODE}, {6'd0, prev_mode});
      tick();
      chk("press_mode", {6'd0, bus_a.MODE}, {6'd0, exp_mode});
      chk("press_leds", {4'd0, bus_a.LEDS}, {4'd0, exp_leds});
      btn = 1'b0;
      repeat (8) begin
         tick();
         chk("release_mode", {6'd0, bus_a.MODE}, {6'd0, exp_mode});
      end
   endtask

   initial begin
      logic [3:0] scan_exp [8];
      int ones_a;
      int ones_z;
      int ones_f;

      scan_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                   4'b0010, 4'b0001, 4'b0010, 4'b0100};

      // 1. Reset and binary count
      CLR = 1'b1;
      ce  = 1'b0;
      btn = 1'b0;
      repeat (3) begin
         tick();
         chk("rst_leds", {4'd0, bus_a.LEDS}, 8'd0);
         chk("rst_mode", {6'd0, bus_a.MODE}, 8'd0);
      end
      CLR = 1'b0;
      for (int i = 1; i <= 17; i++) begin
         ce = 1'b1;
         tick();
         ce = 1'b0;
         chk("bin_step", {4'd0, bus_a.LEDS}, {4'd0, i[3:0]});
         tick();
         chk("bin_hold", {4'd0, bus_a.LEDS}, {4'd0, i[3:0]});
      end
      chk("bin_mode", {6'd0, bus_a.MODE}, 8'd0);

      // 2. Bounce rejection, single accepted press, release, short glitch
      for (int s = 0; s < 10; s++) begin
         btn = (s % 2 == 0) ? 1'b1 : 1'b0;
         repeat (2) begin
            tick();
            chk("bounce_mode", {6'd0, bus_a.MODE}, 8'd0);
         end
      end
      btn = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("stable_mode", {6'd0, bus_a.MODE}, (k >= 6) ? 8'd1 : 8'd0);
         if (k == 6) begin
            chk("stable_leds", {4'd0, bus_a.LEDS}, 8'd1);
         end
      end
      btn = 1'b0;
      repeat (8) begin
         tick();
         chk("release_mode", {6'd0, bus_a.MODE}, 8'd1);
      end
      btn = 1'b1;
      repeat (3) tick();
      btn = 1'b0;
      repeat (10) begin
         tick();
         chk("glitch_mode", {6'd0, bus_a.MODE}, 8'd1);
      end

      // 3. Scanner
      chk("scan_init", {4'd0, bus_a.LEDS}, 8'd1);
      for (int i = 0; i < 8; i++) begin
         ce = 1'b1;
         tick();
         ce = 1'b0;
         chk("scan_step", {4'd0, bus_a.LEDS}, {4'd0, scan_exp[i]});
      end

      // 4. Blink, then press colliding with CE
      press(2'd2, 4'h0);
      ce = 1'b1;
      tick();
      ce = 1'b0;
      chk("blink_on", {4'd0, bus_a.LEDS}, 8'h0F);
      ce = 1'b1;
      tick();
      ce = 1'b0;
      chk("blink_off", {4'd0, bus_a.LEDS}, 8'h00);
      btn = 1'b1;
      repeat (5) tick();
      ce = 1'b1;
      tick();
      ce = 1'b0;
      chk("coll_mode_a", {6'd0, bus_a.MODE}, 8'd3);
      chk("coll_mode_z", {6'd0, bus_z.MODE}, 8'd3);
      chk("coll_mode_f", {6'd0, bus_f.MODE}, 8'd3);
      chk("coll_leds_a", {4'd0, bus_a.LEDS}, {4'd0, dim_exp(4)});
      chk("coll_leds_z", {4'd0, bus_z.LEDS}, 8'h00);
      chk("coll_leds_f", {4'd0, bus_f.LEDS}, 8'h0F);
      btn = 1'b0;
      repeat (8) begin
         tick();
         chk("dim_release", {6'd0, bus_a.MODE}, 8'd3);
      end

      // 5. DIM duty over two PWM periods, CE pulses must have no effect
      ones_a = 0;
      ones_z = 0;
      ones_f = 0;
      for (int i = 0; i < 32; i++) begin
         ce = (i % 5 == 0) ? 1'b1 : 1'b0;
         tick();
         ce = 1'b0;
         chk("dim4_slot", {4'd0, bus_a.LEDS}, {4'd0, dim_exp(4)});
         chk("dim0_slot", {4'd0, bus_z.LEDS}, 8'h00);
         chk("dim16_slot", {4'd0, bus_f.LEDS}, 8'h0F);
         if (bus_a.LEDS == 4'hF) ones_a++;
         if (bus_z.LEDS == 4'hF) ones_z++;
         if (bus_f.LEDS == 4'hF) ones_f++;
      end
      chk("dim4_count", ones_a[7:0], 8'd8);
      chk("dim0_count", ones_z[7:0], 8'd0);
      chk("dim16_count", ones_f[7:0], 8'd32);

      // 6. Async reset in SCAN at 1000 with a half-counted debounce
      press(2'd0, 4'h0);
      press(2'd1, 4'h1);
      for (int i = 0; i < 3; i++) begin
         ce = 1'b1;
         tick();
         ce = 1'b0;
         chk("pre_rst_scan", {4'd0, bus_a.LEDS}, {4'd0, scan_exp[i]});
      end
      btn = 1'b1;
      repeat (4) tick();
      chk("pre_rst_mode", {6'd0, bus_a.MODE}, 8'd1);
      #2;
      CLR = 1'b1;
      #1;
      chk("async_leds", {4'd0, bus_a.LEDS}, 8'd0);
      chk("async_mode", {6'd0, bus_a.MODE}, 8'd0);
      n_edges = 0;
      btn = 1'b0;
      repeat (3) begin
         tick();
         chk("clr_hold_mode", {6'd0, bus_a.MODE}, 8'd0);
      end
      CLR = 1'b0;
      repeat (3) tick();
      chk("post_rst_mode", {6'd0, bus_a.MODE}, 8'd0);
      press(2'd1, 4'h1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
